inst_loader: RTL and testbench



---
 rtl/inst_loader.sv | 147 ++++++++++++++
 tb/tb_inst_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// Instruction loader: accepts a stream of 32-bit words over a valid/ready
// handshake, writes them into the instruction RAM at consecutive byte
// addresses starting at PC_INITIAL, then holds the CPU in reset for a few
// more cycles before releasing it.
module inst_loader #(
    parameter logic [31:0] PC_INITIAL  = 32'hbfc00000,
    parameter int          MAX_WORDS   = 1024,
    parameter int          HOLD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        inst_ram_write_enable,
    output logic [31:0] inst_ram_write_data,
    output logic [31:0] inst_ram_write_address,
    output logic        debug,
    output logic        cpu_reset,
    output logic [10:0] word_count,
    output logic        error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_RUN
    } state_t;

    // The HOLD counter counts down from HOLD_CYCLES-1 to 0; the cycle in which
    // it reads 0 is the last HOLD cycle.
    localparam int          HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [10:0] MAX_CNT   = 11'(MAX_WORDS);

    state_t             state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               in_ready_q, in_ready_d;
    logic               debug_q, debug_d;
    logic               cpu_reset_q, cpu_reset_d;
    logic               we_q, we_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        waddr_q, waddr_d;
    logic [10:0]        count_q, count_d;
    logic               error_q, error_d;

    logic               hs;
    logic [10:0]        count_inc;

    // A word is taken when the registered ready is high at the sampling edge;
    // ready is only ever high in LOAD, so start can never coincide with it.
    assign hs        = in_valid & in_ready_q;
    assign count_inc = count_q + 11'd1;

    // Next-state, write-port and session-counter logic.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        we_d    = 1'b0;
        wdata_d = wdata_q;
        waddr_d = waddr_q;
        count_d = count_q;
        error_d = error_q;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                // start is deliberately ignored while a session is running
                if (hs) begin
                    we_d    = 1'b1;
                    wdata_d = in_data;
                    waddr_d = PC_INITIAL + {19'b0, count_q, 2'b00};
                    count_d = count_inc;
                    if (in_last || (count_inc == MAX_CNT)) begin
                        state_d = S_HOLD;
                        hold_d  = HOLD_LAST;
                        error_d = ~in_last;
                    end
                end
            end
            S_HOLD: begin
                if (hold_q == '0) state_d = S_RUN;
                else              hold_d  = hold_q - 1'b1;
            end
            S_RUN: begin
                if (start) state_d = S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase

        // Fresh session: counters restart on every entry into LOAD.
        if ((state_d == S_LOAD) && (state_q != S_LOAD)) begin
            count_d = '0;
            error_d = 1'b0;
        end
    end

    // Control outputs are decoded from the next state so they line up with
    // the registered state in the same cycle.
    always_comb begin
        in_ready_d  = (state_d == S_LOAD);
        debug_d     = (state_d == S_LOAD) || (state_d == S_HOLD);
        cpu_reset_d = (state_d == S_RUN);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            in_ready_q  <= 1'b0;
            debug_q     <= 1'b0;
            cpu_reset_q <= 1'b0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            waddr_q     <= PC_INITIAL;
            count_q     <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            in_ready_q  <= in_ready_d;
            debug_q     <= debug_d;
            cpu_reset_q <= cpu_reset_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            waddr_q     <= waddr_d;
            count_q     <= count_d;
            error_q     <= error_d;
        end
    end

    assign in_ready               = in_ready_q;
    assign debug                  = debug_q;
    assign cpu_reset              = cpu_reset_q;
    assign inst_ram_write_enable  = we_q;
    assign inst_ram_write_data    = wdata_q;
    assign inst_ram_write_address = waddr_q;
    assign word_count             = count_q;
    assign error                  = error_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: a scoreboard queue holds the writes the
// bench expects, and a negedge monitor pops and compares each RAM write.
module tb_inst_loader;

    localparam logic [31:0] PC = 32'hbfc00000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] waddr;
    logic        debug;
    logic        cpu_reset;
    logic [10:0] word_count;
    logic        error;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_cnt  = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    inst_loader #(
        .PC_INITIAL (PC),
        .MAX_WORDS  (4),
        .HOLD_CYCLES(4)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .start                 (start),
        .in_valid              (in_valid),
        .in_data               (in_data),
        .in_last               (in_last),
        .in_ready              (in_ready),
        .inst_ram_write_enable (we),
        .inst_ram_write_data   (wdata),
        .inst_ram_write_address(waddr),
        .debug                 (debug),
        .cpu_reset             (cpu_reset),
        .word_count            (word_count),
        .error                 (error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // every write strobe must match the oldest outstanding expected write
    always @(negedge clk) begin
        if (we === 1'b1) begin
            n_checks++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_write observed addr=%h data=%h expected no write", waddr, wdata);
            end
            if (sb.size() != 0) begin
                logic [63:0] e;
                e = sb.pop_front();
                chk("write_addr", waddr, e[63:32]);
                chk("write_data", wdata, e[31:0]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        step();
        start = 1'b0;
        exp_cnt = 0;
    endtask

    // drive one word; acc says whether the bench expects it to be taken
    task automatic send(input logic [31:0] d, input logic last, input logic acc);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        chk("in_ready_before_word", in_ready, acc);
        if (acc) begin
            sb.push_back({PC + 32'(exp_cnt) * 32'd4, d});
            exp_cnt++;
        end
        step();
        chk("we_after_word", we, acc);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        step();
        chk("we_idle", we, 1'b0);
    endtask

    task automatic wait_run(input string tag);
        int k = 0;
        while (cpu_reset !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        chk(tag, cpu_reset, 1'b1);
        chk({tag, "_debug"}, debug, 1'b0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1'b0);
        chk({tag, "_we"}, we, 1'b0);
        chk({tag, "_wdata"}, wdata, 32'h0);
        chk({tag, "_waddr"}, waddr, PC);
        chk({tag, "_debug"}, debug, 1'b0);
        chk({tag, "_cpu_reset"}, cpu_reset, 1'b0);
        chk({tag, "_count"}, word_count, 11'd0);
        chk({tag, "_error"}, error, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset values, applied asynchronously before any clock edge
        #2 reset = 1'b0;
        #1 chk_reset_vals("por");
        step();
        step();
        reset = 1'b1;
        step();
        step();
        chk("idle_ready", in_ready, 1'b0);
        chk("idle_cpu_reset", cpu_reset, 1'b0);

        // ---- three back-to-back words, last on the third
        start_pulse();
        chk("s1_ready", in_ready, 1'b1);
        chk("s1_debug", debug, 1'b1);
        chk("s1_cpu_reset", cpu_reset, 1'b0);
        send(32'h200FFAF4, 1'b0, 1'b1);
        send(32'h3C180123, 1'b0, 1'b1);
        send(32'h01F87820, 1'b1, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("s1_ready_after_last", in_ready, 1'b0);
        chk("s1_count", word_count, 11'd3);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("s1_hold_cpu_reset", cpu_reset, (i == 4));
            chk("s1_hold_debug", debug, (i != 4));
            chk("s1_hold_we", we, 1'b0);
        end
        chk("s1_error", error, 1'b0);
        chk("s1_count_run", word_count, 11'd3);

        // ---- overflow: six words without last, only four accepted
        start_pulse();
        send(32'h11110000, 1'b0, 1'b1);
        send(32'h11110001, 1'b0, 1'b1);
        send(32'h11110002, 1'b0, 1'b1);
        send(32'h11110003, 1'b0, 1'b1);
        chk("ov_error", error, 1'b1);
        chk("ov_count", word_count, 11'd4);
        send(32'h11110004, 1'b0, 1'b0);
        send(32'h11110005, 1'b0, 1'b0);
        in_valid = 1'b0;
        wait_run("ov_run");
        chk("ov_error_run", error, 1'b1);
        chk("ov_count_run", word_count, 11'd4);

        // ---- restart from RUN clears error, single last word
        start_pulse();
        chk("rs_cpu_reset", cpu_reset, 1'b0);
        chk("rs_debug", debug, 1'b1);
        chk("rs_error_cleared", error, 1'b0);
        chk("rs_count_cleared", word_count, 11'd0);
        send(32'hCAFEF00D, 1'b1, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_run("rs_run");
        chk("rs_count", word_count, 11'd1);
        chk("rs_error", error, 1'b0);

        // ---- in_valid toggling 1,0,1,0
        start_pulse();
        send(32'hA0000001, 1'b0, 1'b1);
        idle();
        send(32'hA0000002, 1'b0, 1'b1);
        idle();
        send(32'hA0000003, 1'b1, 1'b1);
        idle();
        wait_run("tg_run");
        chk("tg_count", word_count, 11'd3);

        // ---- start ignored in LOAD (even alongside a word) and in HOLD
        start_pulse();
        start = 1'b1;
        send(32'hB0000001, 1'b0, 1'b1);
        start = 1'b0;
        chk("ig_load_ready", in_ready, 1'b1);
        chk("ig_load_count", word_count, 11'd1);
        send(32'hB0000002, 1'b1, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ig_hold_ready", in_ready, 1'b0);
        chk("ig_hold_debug", debug, 1'b1);
        chk("ig_hold_count", word_count, 11'd2);
        wait_run("ig_run");
        chk("ig_count_run", word_count, 11'd2);

        // ---- reset during the second word of a session
        start_pulse();
        send(32'hD0000001, 1'b0, 1'b1);
        in_data  = 32'hD0000002;
        in_valid = 1'b1;
        @(negedge clk);
        #1 reset = 1'b0;
        #1 chk_reset_vals("mid");
        in_valid = 1'b0;
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_ready", in_ready, 1'b0);
            chk("post_rst_debug", debug, 1'b0);
            chk("post_rst_we", we, 1'b0);
        end
        start_pulse();
        chk("resume_ready", in_ready, 1'b1);
        send(32'hE0000001, 1'b1, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_run("resume_run");
        chk("resume_count", word_count, 11'd1);

        step();
        step();
        chk("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
